// File: rtl/imm_gen_pkg.sv
// Shared types for the immediate-generation stage.
// Format-select encoding and small elaboration helpers.
package imm_gen_pkg;

    localparam int IMM_SRC_W = 3;

    typedef enum logic [IMM_SRC_W-1:0] {
        IMM_I   = 3'b000,
        IMM_S   = 3'b001,
        IMM_B   = 3'b010,
        IMM_J   = 3'b011,
        IMM_U   = 3'b100,
        IMM_Z   = 3'b101,
        IMM_SH  = 3'b110,
        IMM_RSV = 3'b111
    } imm_src_e;

    function automatic bit xlen_ok(input int xlen);
        return (xlen == 32) || (xlen == 64);
    endfunction

endpackage

// File: rtl/imm_gen_stage_extend.sv
// Combinational RISC-V immediate extractor, XLEN 32 or 64.
// Every format is built at 64 bits and truncated to XLEN.
module imm_extend
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]          instr,
    input  logic [IMM_SRC_W-1:0] imm_src,
    output logic [XLEN-1:0]      imm,
    output logic                 illegal
);

    logic [63:0] imm64;
    logic [5:0]  shamt;
    logic        s;

    assign s = instr[31];

    // RV64 shifts carry a 6-bit shamt; RV32 only 5.
    assign shamt = (XLEN == 64) ? instr[25:20] : {1'b0, instr[24:20]};

    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        unique case (imm_src)
            IMM_I:   imm64 = {{52{s}}, instr[31:20]};
            IMM_S:   imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            IMM_B:   imm64 = {{52{s}}, instr[7], instr[30:25],
                              instr[11:8], 1'b0};
            IMM_J:   imm64 = {{44{s}}, instr[19:12], instr[20],
                              instr[30:21], 1'b0};
            IMM_U:   imm64 = {{32{s}}, instr[31:12], 12'b0};
            IMM_Z:   imm64 = {59'b0, instr[19:15]};
            IMM_SH:  imm64 = {58'b0, shamt};
            IMM_RSV: illegal = 1'b1;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a two-entry skid buffer.
// in_ready comes straight from the skid valid flop, never from out_ready.
module imm_gen_stage
    import imm_gen_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic [IMM_SRC_W-1:0] in_imm_src,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [XLEN-1:0]      out_imm,
    output logic [IMM_SRC_W-1:0] out_imm_src,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 out_illegal
);

    if (!xlen_ok(XLEN)) begin : g_bad_xlen
        $error("imm_gen_stage: XLEN must be 32 or 64");
    end

    logic [XLEN-1:0] ext_imm;
    logic            ext_illegal;

    imm_extend #(
        .XLEN(XLEN)
    ) u_extend (
        .instr   (in_instr),
        .imm_src (in_imm_src),
        .imm     (ext_imm),
        .illegal (ext_illegal)
    );

    logic                 main_valid_q, main_valid_d;
    logic [XLEN-1:0]      main_imm_q,   main_imm_d;
    logic [IMM_SRC_W-1:0] main_src_q,   main_src_d;
    logic [TAG_W-1:0]     main_tag_q,   main_tag_d;
    logic                 main_ill_q,   main_ill_d;

    logic                 skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]      skid_imm_q,   skid_imm_d;
    logic [IMM_SRC_W-1:0] skid_src_q,   skid_src_d;
    logic [TAG_W-1:0]     skid_tag_q,   skid_tag_d;
    logic                 skid_ill_q,   skid_ill_d;

    logic accept;
    logic main_load;

    assign in_ready  = ~skid_valid_q;
    assign accept    = in_valid & ~skid_valid_q & ~flush;
    assign main_load = ~main_valid_q | out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        main_imm_d   = main_imm_q;
        main_src_d   = main_src_q;
        main_tag_d   = main_tag_q;
        main_ill_d   = main_ill_q;
        skid_valid_d = skid_valid_q;
        skid_imm_d   = skid_imm_q;
        skid_src_d   = skid_src_q;
        skid_tag_d   = skid_tag_q;
        skid_ill_d   = skid_ill_q;

        // Flush only drops valids; payload flops keep their contents.
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (main_load) begin
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_imm_d   = skid_imm_q;
                main_src_d   = skid_src_q;
                main_tag_d   = skid_tag_q;
                main_ill_d   = skid_ill_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_valid_d = 1'b1;
                main_imm_d   = ext_imm;
                main_src_d   = in_imm_src;
                main_tag_d   = in_tag;
                main_ill_d   = ext_illegal;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_imm_d   = ext_imm;
            skid_src_d   = in_imm_src;
            skid_tag_d   = in_tag;
            skid_ill_d   = ext_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid_q <= 1'b0;
            main_imm_q   <= '0;
            main_src_q   <= '0;
            main_tag_q   <= '0;
            main_ill_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_imm_q   <= '0;
            skid_src_q   <= '0;
            skid_tag_q   <= '0;
            skid_ill_q   <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            main_imm_q   <= main_imm_d;
            main_src_q   <= main_src_d;
            main_tag_q   <= main_tag_d;
            main_ill_q   <= main_ill_d;
            skid_valid_q <= skid_valid_d;
            skid_imm_q   <= skid_imm_d;
            skid_src_q   <= skid_src_d;
            skid_tag_q   <= skid_tag_d;
            skid_ill_q   <= skid_ill_d;
        end
    end

    assign out_valid   = main_valid_q;
    assign out_imm     = main_imm_q;
    assign out_imm_src = main_src_q;
    assign out_tag     = main_tag_q;
    assign out_illegal = main_ill_q;

endmodule
